// File: rtl/mem_pkg.sv
// Shared types and encodings for the byte-addressable RAM initiator.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

endpackage

// File: rtl/mem_access_ctrl.sv
// Sequences byte/halfword core requests into one or two 8-bit RAM accesses
// and returns a single-cycle response carrying assembled load data.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_r_w,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic              size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;

    logic              ram_en_q, ram_en_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_r_w_q, ram_r_w_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_rdata_q, rsp_rdata_d;

    // Next-state, request latch and read-data assembly.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 16'h0000;
                    state_d = ACC0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC0: begin
                if (size_q == SIZE_HALF) begin
                    state_d = ACC1;
                end else if (we_q == RAM_WRITE) begin
                    state_d = RESP;
                end else begin
                    state_d = CAP;
                end
            end
            ACC1: begin
                // Registered RAM data here belongs to the ACC0 (low byte) read.
                if (we_q == RAM_READ) begin
                    rdata_d[7:0] = ram_rdata;
                    state_d      = CAP;
                end else begin
                    state_d = RESP;
                end
            end
            CAP: begin
                if (size_q == SIZE_HALF) begin
                    rdata_d[15:8] = ram_rdata;
                end else begin
                    rdata_d[7:0] = ram_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered
    // so that every RAM-facing signal can come straight from a flop.
    always_comb begin
        ram_en_d    = 1'b0;
        ram_addr_d  = '0;
        ram_r_w_d   = RAM_READ;
        ram_wdata_d = 8'h00;
        case (state_d)
            ACC0: begin
                ram_en_d    = 1'b1;
                ram_addr_d  = addr_d;
                ram_r_w_d   = we_d;
                ram_wdata_d = wdata_d[7:0];
            end
            ACC1: begin
                ram_en_d    = 1'b1;
                ram_addr_d  = addr_d + ADDR_ONE;
                ram_r_w_d   = we_d;
                ram_wdata_d = wdata_d[15:8];
            end
            default: begin
                ram_en_d    = 1'b0;
                ram_addr_d  = '0;
                ram_r_w_d   = RAM_READ;
                ram_wdata_d = 8'h00;
            end
        endcase
        rsp_valid_d = (state_d == RESP);
        if ((state_d == RESP) && (we_q == RAM_READ)) begin
            rsp_rdata_d = rdata_d;
        end else begin
            rsp_rdata_d = 16'h0000;
        end
    end

    // State, request holding and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_r_w_q   <= 1'b0;
            ram_wdata_q <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_r_w_q   <= ram_r_w_d;
            ram_wdata_q <= ram_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Gated with rst_n so ready is low throughout reset, high right after release.
    assign req_ready = rst_n && (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_r_w   = ram_r_w_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: behavioural RAM, byte-level memory model and randomized traffic.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_size;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ram_en;
    logic [7:0]  ram_addr;
    logic        ram_r_w;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int checks;
    int failures;

    logic [7:0] ram_mem   [256];
    logic [7:0] model_mem [256];
    logic       known     [256];

    mem_access_ctrl #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_r_w   (ram_r_w),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port model: clock gated by ram_en, registered read data.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_r_w) ram_mem[ram_addr] <= ram_wdata;
            else         ram_rdata <= ram_mem[ram_addr];
        end
    end

    // One request, checked every cycle from accept through the first ready cycle.
    task automatic do_req(input logic we, input logic sz, input logic [7:0] a,
                          input logic [15:0] wd, input logic hold, input string nm);
        int          lat;
        logic [7:0]  a1;
        logic [15:0] exp_rd;
        logic        exp_en;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_wd;
        a1     = a + 8'd1;
        lat    = we ? (sz ? 3 : 2) : (sz ? 4 : 3);
        exp_rd = we ? 16'h0000 : (sz ? {model_mem[a1], model_mem[a]} : {8'h00, model_mem[a]});
        if (we) begin
            model_mem[a] = wd[7:0];
            known[a]     = 1'b1;
            if (sz) begin
                model_mem[a1] = wd[15:8];
                known[a1]     = 1'b1;
            end
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL %s ready_at_accept got=%b exp=1", nm, req_ready);
        end
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (!hold) begin
                req_valid = 1'b0;
            end else begin
                req_we = 1'($urandom); req_size = 1'($urandom);
                req_addr = 8'($urandom); req_wdata = 16'($urandom);
            end
            exp_en   = (c == 1) || (c == 2 && sz);
            exp_addr = (c == 1) ? a : a1;
            exp_wd   = (c == 1) ? wd[7:0] : wd[15:8];
            checks++;
            if (ram_en !== exp_en) begin
                failures++; $display("FAIL %s ram_en c=%0d got=%b exp=%b", nm, c, ram_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (ram_addr !== exp_addr || ram_r_w !== we || (we && ram_wdata !== exp_wd)) begin
                    failures++;
                    $display("FAIL %s ram_access c=%0d got=%h/%b/%h exp=%h/%b/%h",
                             nm, c, ram_addr, ram_r_w, ram_wdata, exp_addr, we, exp_wd);
                end
            end
            checks++;
            if (rsp_valid !== (c == lat) || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s rsp_valid/ready c=%0d got=%b/%b exp=%b/0",
                         nm, c, rsp_valid, req_ready, (c == lat));
            end
            if (c == lat) begin
                checks++;
                if (rsp_rdata !== exp_rd) begin
                    failures++; $display("FAIL %s rsp_rdata got=%h exp=%h", nm, rsp_rdata, exp_rd);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
        req_addr = 8'h00; req_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 ||
            ram_en !== 1'b0 || ram_addr !== 8'h00 || ram_r_w !== 1'b0 || ram_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_values got rdy=%b rv=%b rd=%h en=%b a=%h rw=%b wd=%h exp all 0",
                     req_ready, rsp_valid, rsp_rdata, ram_en, ram_addr, ram_r_w, ram_wdata);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_byte();
        do_req(1'b1, 1'b0, 8'h10, 16'h00A5, 1'b0, "byte_store");
        do_req(1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, "byte_load");
    endtask

    task automatic test_half();
        do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0, "half_store");
        do_req(1'b0, 1'b1, 8'h20, 16'h0000, 1'b0, "half_load");
        do_req(1'b0, 1'b0, 8'h21, 16'h0000, 1'b0, "half_hi_byte");
    endtask

    task automatic test_wrap();
        do_req(1'b1, 1'b1, 8'hFF, 16'h1234, 1'b0, "wrap_store");
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000, 1'b0, "wrap_load");
        do_req(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, "wrap_byte0");
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 1'b0, 8'h30, 16'h0011, 1'b1, "b2b_0");
        do_req(1'b0, 1'b0, 8'h30, 16'h0000, 1'b1, "b2b_1");
        do_req(1'b1, 1'b1, 8'h31, 16'h7788, 1'b1, "b2b_2");
        do_req(1'b0, 1'b1, 8'h30, 16'h0000, 1'b1, "b2b_3");
        req_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_addr = 8'h40; req_wdata = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 8'h41) begin
            failures++; $display("FAIL abort_in_acc1 got en=%b a=%h exp en=1 a=41", ram_en, ram_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_en !== 1'b0 || ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin
            failures++; $display("FAIL abort_ram_drop got en=%b a=%h wd=%h exp 0", ram_en, ram_addr, ram_wdata);
        end
        model_mem[8'h40] = 8'hFE;
        known[8'h40]     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || ram_en !== 1'b0) begin
                failures++; $display("FAIL abort_no_rsp got rv=%b en=%b exp 0", rsp_valid, ram_en);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL abort_release_ready got=%b exp=1", req_ready);
        end
        do_req(1'b0, 1'b0, 8'h40, 16'h0000, 1'b0, "abort_low_byte");
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 1'b0; req_addr = 8'h10; req_wdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || ram_en !== 1'b0 || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_in_reset got rdy=%b en=%b rv=%b exp 0", req_ready, ram_en, rsp_valid);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL hold_release_ready got=%b exp=1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 8'h10 || ram_r_w !== 1'b0) begin
            failures++; $display("FAIL hold_first_accept got en=%b a=%h rw=%b exp 1/10/0", ram_en, ram_addr, ram_r_w);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== {8'h00, model_mem[8'h10]}) begin
            failures++;
            $display("FAIL hold_load_rsp got rv=%b rd=%h exp 1/%h", rsp_valid, rsp_rdata, {8'h00, model_mem[8'h10]});
        end
    endtask

    task automatic test_random();
        logic        we, sz, hold;
        logic [7:0]  a;
        logic [15:0] wd;
        for (int n = 0; n < 40; n++) begin
            we   = 1'($urandom);
            sz   = 1'($urandom);
            hold = 1'($urandom);
            a    = 8'($urandom_range(0, 15)) + 8'hF8;
            wd   = 16'($urandom);
            if (!we && !(known[a] && (!sz || known[a + 8'd1]))) we = 1'b1;
            do_req(we, sz, a, wd, hold, "random");
        end
        req_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        test_reset();
        test_byte();
        test_half();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_reset_hold();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator side of the byte-addressable RAM port. Accepts byte and halfword load/store requests from the CPU core over a valid/ready handshake, sequences them into one or two 8-bit RAM transactions, and returns a single-cycle response with read data. Sits between the core's load/store path and one port of the dual-port RAM.

## Interface
- ADDR_W, 8, RAM address width; all address arithmetic is modulo 2^ADDR_W.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE and rst_n high
- req_we  in  1  0 = load, 1 = store
- req_size  in  1  0 = byte, 1 = halfword
- req_addr  in  ADDR_W  byte address of the first (low) byte
- req_wdata  in  16  store data; [7:0] for byte stores
- rsp_valid  out  1  one-cycle completion pulse for every accepted request
- rsp_rdata  out  16  load data, valid with rsp_valid; 0 for stores
- ram_en  out  1  RAM enable; the RAM gates its clock with this signal
- ram_addr  out  ADDR_W  RAM address
- ram_r_w  out  1  0 = read, 1 = write
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM registered read data, valid the cycle after a read access

## Operation
- States: IDLE, ACC0, ACC1, CAP, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, latch we/size/addr/wdata and go to ACC0.
- ACC0: access the low byte at addr with ram_wdata = wdata[7:0]. Next state:
  - halfword: ACC1
  - byte load: CAP
  - byte store: RESP
- ACC1: access the high byte at addr+1 (0xFF wraps to 0x00) with ram_wdata = wdata[15:8]. On loads, capture ram_rdata into rdata[7:0]. Next state: CAP for loads, RESP for stores.
- CAP: no RAM access. Capture ram_rdata into rdata[15:8] for halfword loads, or into rdata[7:0] for byte loads. Next state: RESP.
- RESP: rsp_valid = 1 and rsp_rdata driven, then IDLE.
- Little-endian: the byte at the lower address goes to bits [7:0]. Byte loads zero-extend.
- Misaligned halfwords are legal; there are no alignment faults.
- There is no response backpressure. The core must sample rsp_valid when it pulses.
- Only one request is outstanding at a time. Requests presented outside IDLE are ignored, and req_valid may be held.
- Reset (asynchronous, any state): state goes to IDLE, all outputs go to 0, and no response is issued.
  - A halfword store aborted after ACC0 leaves the low byte written. This is accepted behaviour.

## Timing
- ram_en, ram_addr, ram_r_w and ram_wdata are flop outputs, so no glitches reach the RAM clock gate. They change only on clk edges and are high/valid exactly during ACC0 and ACC1.
- ram_en = 0 in IDLE, CAP and RESP.
- Latency from the accept edge to the rsp_valid cycle:
  - byte store: 2 cycles
  - halfword store: 3 cycles
  - byte load: 3 cycles
  - halfword load: 4 cycles
- req_ready rises in the cycle after RESP. Back-to-back throughput is therefore one request per (latency + 1) cycles.
- Reset values: req_ready 0 while rst_n is low, 1 in the first cycle after release. rsp_valid 0, rsp_rdata 0, ram_en 0, ram_addr 0, ram_r_w 0, ram_wdata 0.

## Structure
- Shared package mem_pkg holds:
  - state enum (IDLE, ACC0, ACC1, CAP, RESP)
  - size encodings SIZE_BYTE = 1'b0, SIZE_HALF = 1'b1
  - access encodings RAM_READ = 1'b0, RAM_WRITE = 1'b1
- Single module with no sub-module. It contains one FSM, a request holding register, and a 16-bit read-assembly register.

## Test plan
- Byte store addr 0x10, data 0x00A5 -> ACC0 drives ram_en=1, ram_addr=0x10, ram_r_w=1, ram_wdata=0xA5. rsp_valid follows 2 cycles after accept with rsp_rdata=0. Then a byte load from 0x10 -> rsp_rdata=0x00A5 after 3 cycles.
- Halfword store addr 0x20, data 0xBEEF -> RAM writes 0xEF@0x20 then 0xBE@0x21. A halfword load from 0x20 returns 0xBEEF after 4 cycles.
- Halfword store addr 0xFF, data 0x1234 -> writes 0x34@0xFF and 0x12@0x00 (wrap). A halfword load from 0xFF returns 0x1234.
- Hold req_valid=1 with alternating requests -> each is accepted only when req_ready=1, with no duplicate or dropped accesses. Check the exact cycle of each ram_en pulse and each rsp_valid.
- Assert rst_n low during ACC1 of a halfword store 0x40/0xCAFE -> ram_en drops immediately and no rsp_valid is issued. After release, req_ready=1, and a byte load from 0x40 returns 0x00FE.
- Hold rst_n low with req_valid=1 -> req_ready=0, ram_en=0, rsp_valid=0 throughout. The first accept happens in the cycle after release.
